// File: rtl/shift_req_scheduler.sv
// Round-robin scheduler sharing one external barrel shifter among NUM_REQ requesters,
// splitting long shifts into passes of at most 2^SHIFT_BITS-1. Optional: SHIFT_SAT_EN.
module shift_req_scheduler #(
   parameter int WIDTH      = 8,
   parameter int SHIFT_BITS = 3,
   parameter int NUM_REQ    = 4,
   parameter int AMT_BITS   = 5,
   parameter int ID_BITS    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]     req_data,
   input  logic [NUM_REQ*AMT_BITS-1:0]  req_amt,
   input  logic [NUM_REQ-1:0]           req_dir,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WIDTH-1:0]             rsp_data,
   output logic [ID_BITS-1:0]           rsp_id,
`ifdef SHIFT_SAT_EN
   output logic                         rsp_ovf,
`endif
   output logic [WIDTH-1:0]             sh_data_in,
   output logic [SHIFT_BITS-1:0]        sh_amount,
   output logic                         sh_dir,
   input  logic [WIDTH-1:0]             sh_data_out
);

   localparam int MAX_STEP = (1 << SHIFT_BITS) - 1;
   localparam int REM_BITS = $clog2(WIDTH + 1);
   localparam int CMP_A    = (AMT_BITS > REM_BITS) ? AMT_BITS : REM_BITS;
   localparam int CMP_BITS = (CMP_A > SHIFT_BITS) ? CMP_A : SHIFT_BITS;

   typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

   state_t                state, state_next;
   logic [WIDTH-1:0]      acc;
   logic                  dir_q;
   logic [ID_BITS-1:0]    id_q;
   logic [ID_BITS-1:0]    last_grant;
   logic [REM_BITS-1:0]   rem;

   logic                  grant_found;
   logic [ID_BITS-1:0]    grant_idx;
   logic [ID_BITS-1:0]    cand;
   logic                  accept;
   logic [WIDTH-1:0]      sel_data;
   logic [AMT_BITS-1:0]   sel_amt;
   logic                  sel_dir;
   logic [REM_BITS-1:0]   amt_clamped;
   logic [SHIFT_BITS-1:0] step;
   logic [REM_BITS-1:0]   rem_after;
   logic [WIDTH-1:0]      result;

   // Round-robin search starting just after the previous winner.
   // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_BITS'((int'(last_grant) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign accept      = (state == IDLE) && grant_found && !rst;
   assign sel_data    = req_data[int'(grant_idx)*WIDTH +: WIDTH];
   assign sel_amt     = req_amt[int'(grant_idx)*AMT_BITS +: AMT_BITS];
   assign sel_dir     = req_dir[grant_idx];
   assign amt_clamped = (CMP_BITS'(sel_amt) >= CMP_BITS'(WIDTH)) ? REM_BITS'(WIDTH)
                                                                  : REM_BITS'(sel_amt);
   assign step        = (CMP_BITS'(rem) > CMP_BITS'(MAX_STEP)) ? SHIFT_BITS'(MAX_STEP)
                                                               : SHIFT_BITS'(rem);
   assign rem_after   = rem - REM_BITS'(step);

   always_comb begin
      state_next = state;
      req_ready  = '0;
      rsp_valid  = 1'b0;
      sh_amount  = '0;
      sh_dir     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               req_ready[grant_idx] = 1'b1;
               state_next = (amt_clamped == '0) ? RESP : SHIFT;
            end
         end
         SHIFT: begin
            sh_amount = step;
            sh_dir    = dir_q;
            if (rem_after == '0) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

`ifdef SHIFT_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             ovf_q;
   logic             sign_q;
   logic [WIDTH-1:0] back_shift;

   // Shifting the pass result back must reproduce the pass input, else bits or sign were lost.
   assign back_shift = $signed(sh_data_out) >>> step;
   assign result     = ovf_q ? (sign_q ? SAT_NEG : SAT_POS) : acc;
   assign rsp_ovf    = rsp_valid & ovf_q;
`else
   assign result     = acc;
`endif

   // NOTE: only control/datapath registers are reset here; there is no storage array to clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         dir_q      <= 1'b0;
         id_q       <= '0;
         last_grant <= ID_BITS'(NUM_REQ - 1);
         rem        <= '0;
`ifdef SHIFT_SAT_EN
         ovf_q      <= 1'b0;
         sign_q     <= 1'b0;
`endif
      end else if (accept) begin
         acc        <= sel_data;
         dir_q      <= sel_dir;
         id_q       <= grant_idx;
         last_grant <= grant_idx;
         rem        <= amt_clamped;
`ifdef SHIFT_SAT_EN
         ovf_q      <= 1'b0;
         sign_q     <= sel_data[WIDTH-1];
`endif
      end else if (state == SHIFT) begin
         acc <= sh_data_out;
         rem <= rem_after;
`ifdef SHIFT_SAT_EN
         if (!dir_q && (back_shift != acc)) ovf_q <= 1'b1;
`endif
      end
   end

   assign sh_data_in = acc;
   assign rsp_data   = rsp_valid ? result : '0;
   assign rsp_id     = rsp_valid ? id_q : '0;

endmodule
